// File: rtl/mod_n_stream_checker.sv
// mod_n_stream_checker: serial divisibility checker for an unbounded binary stream.
// Folds W bits per valid cycle into a running remainder mod DIVISOR, MSB- or LSB-first.
//
// Ports:
//   clk        rising-edge clock
//   resetn     async active-low reset
//   clear      start a new number (not qualified by din_valid)
//   din_valid  din carries W new bits this cycle
//   din        next W-bit chunk of the number
//   dout       value so far divisible by DIVISOR and at least one bit seen
//   remainder  value so far mod DIVISOR
//   empty      no bits received since reset/clear
//   bit_count  bits received since reset/clear, saturating
module mod_n_stream_checker #(
    parameter int DIVISOR   = 3,
    parameter int W         = 1,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CNT_W     = 16,
    localparam int RW       = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             din_valid,
    input  logic [W-1:0]     din,
    output logic             dout,
    output logic [RW-1:0]    remainder,
    output logic             empty,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [RW:0]    DV       = (RW+1)'(DIVISOR);
    localparam logic [CNT_W:0] CNT_MAX  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0] WINC     = (CNT_W+1)'(W);
    localparam logic [RW-1:0]  ONE      = RW'(1);

    if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
        $error("mod_n_stream_checker: DIVISOR must be 2..255");
    end
    if (W < 1 || W > 8) begin : g_bad_width
        $error("mod_n_stream_checker: W must be 1..8");
    end

    logic [RW-1:0]    rem_q;
    logic [RW-1:0]    wt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             empty_q;

    logic [RW-1:0]    rem_d;
    logic [RW-1:0]    wt_d;
    logic [CNT_W-1:0] cnt_d;
    logic             empty_d;
    logic             dout_d;

    logic [RW-1:0]    r;
    logic [RW-1:0]    w;
    logic [RW:0]      s;
    logic [CNT_W:0]   c;

    // One chunk is folded per cycle through W unrolled stages.
    // Each stage adds at most D-1 to a value below D, so one
    // conditional subtract keeps the remainder in range.
    always_comb begin
        // Out-of-range state (unreachable) falls back to reset values.
        r = ({1'b0, rem_q} < DV) ? rem_q : '0;
        w = ({1'b0, wt_q} < DV) ? wt_q : ONE;
        c = {1'b0, cnt_q};
        s = '0;

        if (clear) begin
            r = '0;
            w = ONE;
            c = '0;
        end

        if (din_valid) begin
            for (int i = 0; i < W; i++) begin
                if (!LSB_FIRST) begin
                    s = {r, din[W-1-i]};
                    if (s >= DV) s = s - DV;
                    r = s[RW-1:0];
                end else begin
                    // w tracks 2^(bit position) mod D.
                    if (din[i]) begin
                        s = {1'b0, r} + {1'b0, w};
                        if (s >= DV) s = s - DV;
                        r = s[RW-1:0];
                    end
                    s = {w, 1'b0};
                    if (s >= DV) s = s - DV;
                    w = s[RW-1:0];
                end
            end
            c = c + WINC;
            if (c > CNT_MAX) c = CNT_MAX;
        end

        rem_d   = r;
        wt_d    = w;
        cnt_d   = c[CNT_W-1:0];
        empty_d = din_valid ? 1'b0 : (clear ? 1'b1 : empty_q);
        dout_d  = !empty_d && (r == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q   <= '0;
            wt_q    <= ONE;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            dout    <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            wt_q    <= wt_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            dout    <= dout_d;
        end
    end

    assign remainder = rem_q;
    assign empty     = empty_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_mod_n_stream_checker.sv
// tb_mod_n_stream_checker: directed vectors on five configurations plus
// a randomised comparison of thirty configurations against a modular model.
module tb_mod_n_stream_checker;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    // ---------------- directed instances ----------------
    logic       clr[5];
    logic       vld[5];
    logic [7:0] dn[5];

    logic o0, e0; logic [1:0] r0; logic [15:0] n0;
    logic o1, e1; logic [2:0] r1; logic [15:0] n1;
    logic o2, e2; logic [1:0] r2; logic [15:0] n2;
    logic o3, e3; logic [2:0] r3; logic [15:0] n3;
    logic o4, e4; logic [1:0] r4; logic [3:0]  n4;

    mod_n_stream_checker #(.DIVISOR(3), .W(1), .LSB_FIRST(1'b0), .CNT_W(16)) u_t1 (
        .clk(clk), .resetn(resetn), .clear(clr[0]), .din_valid(vld[0]),
        .din(dn[0][0:0]), .dout(o0), .remainder(r0), .empty(e0), .bit_count(n0));
    mod_n_stream_checker #(.DIVISOR(5), .W(4), .LSB_FIRST(1'b0), .CNT_W(16)) u_t2 (
        .clk(clk), .resetn(resetn), .clear(clr[1]), .din_valid(vld[1]),
        .din(dn[1][3:0]), .dout(o1), .remainder(r1), .empty(e1), .bit_count(n1));
    mod_n_stream_checker #(.DIVISOR(3), .W(1), .LSB_FIRST(1'b1), .CNT_W(16)) u_t3 (
        .clk(clk), .resetn(resetn), .clear(clr[2]), .din_valid(vld[2]),
        .din(dn[2][0:0]), .dout(o2), .remainder(r2), .empty(e2), .bit_count(n2));
    mod_n_stream_checker #(.DIVISOR(7), .W(1), .LSB_FIRST(1'b0), .CNT_W(16)) u_t4 (
        .clk(clk), .resetn(resetn), .clear(clr[3]), .din_valid(vld[3]),
        .din(dn[3][0:0]), .dout(o3), .remainder(r3), .empty(e3), .bit_count(n3));
    mod_n_stream_checker #(.DIVISOR(3), .W(3), .LSB_FIRST(1'b0), .CNT_W(4)) u_t6 (
        .clk(clk), .resetn(resetn), .clear(clr[4]), .din_valid(vld[4]),
        .din(dn[4][2:0]), .dout(o4), .remainder(r4), .empty(e4), .bit_count(n4));

    // ---------------- random instances ----------------
    function automatic int dof(input int i);
        case (i / 6)
            0: return 2;
            1: return 3;
            2: return 7;
            3: return 10;
            default: return 255;
        endcase
    endfunction
    function automatic int wof(input int i);
        case ((i / 2) % 3)
            0: return 1;
            1: return 3;
            default: return 8;
        endcase
    endfunction
    function automatic int lof(input int i);
        return i % 2;
    endfunction

    localparam int NR = 30;
    logic       rclr, rvld;
    logic [7:0] rdin;
    logic [25:0] act_a [NR];

    for (genvar gi = 0; gi < NR; gi++) begin : g_rnd
        localparam int GD  = dof(gi);
        localparam int GW  = wof(gi);
        localparam int GL  = lof(gi);
        localparam int GRW = (GD > 2) ? $clog2(GD) : 1;
        logic             go, ge;
        logic [GRW-1:0]   gr;
        logic [15:0]      gn;
        mod_n_stream_checker #(.DIVISOR(GD), .W(GW), .LSB_FIRST(GL[0]), .CNT_W(16)) u_r (
            .clk(clk), .resetn(resetn), .clear(rclr), .din_valid(rvld),
            .din(rdin[GW-1:0]), .dout(go), .remainder(gr), .empty(ge), .bit_count(gn));
        assign act_a[gi] = {go, ge, 8'(gr), gn};
    end

    // ---------------- helpers ----------------
    typedef struct {
        int k; bit c; bit v; int din;
        int rem; bit dout; bit emp; int cnt;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic void rd(input int k, output int d, output int r,
                               output int e, output int n);
        d = 0; r = 0; e = 0; n = 0;
        case (k)
            0: begin d = int'(o0); r = int'(r0); e = int'(e0); n = int'(n0); end
            1: begin d = int'(o1); r = int'(r1); e = int'(e1); n = int'(n1); end
            2: begin d = int'(o2); r = int'(r2); e = int'(e2); n = int'(n2); end
            3: begin d = int'(o3); r = int'(r3); e = int'(e3); n = int'(n3); end
            default: begin d = int'(o4); r = int'(r4); e = int'(e4); n = int'(n4); end
        endcase
    endfunction

    task automatic chk_inst(input string nm, input int k, input int rem,
                            input int dout, input int emp, input int cnt);
        int d, r, e, n;
        rd(k, d, r, e, n);
        chk($sformatf("%s.rem", nm), r, rem);
        chk($sformatf("%s.dout", nm), d, dout);
        chk($sformatf("%s.empty", nm), e, emp);
        chk($sformatf("%s.cnt", nm), n, cnt);
    endtask

    task automatic idle();
        for (int k = 0; k < 5; k++) begin
            clr[k] = 1'b0;
            vld[k] = 1'b0;
            dn[k]  = 8'h00;
        end
    endtask

    vec_t tv[22];
    vec_t exq[$];
    logic [NR*26-1:0] rq[$];

    int mv[NR];
    int mw[NR];
    int mc[NR];
    bit me[NR];

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mv[i] = 0; mw[i] = 1; mc[i] = 0; me[i] = 1'b1;
        end
    endtask

    // Value is tracked modulo D using plain multiplies, independent of
    // the bit-by-bit fold inside the design.
    task automatic model_step();
        logic [NR*26-1:0] ex;
        for (int i = 0; i < NR; i++) begin
            int d, w, ch, cs;
            d = dof(i);
            w = wof(i);
            if (rclr) begin
                mv[i] = 0; mw[i] = 1; mc[i] = 0; me[i] = 1'b1;
            end
            if (rvld) begin
                ch = int'(rdin) & ((1 << w) - 1);
                if (lof(i) == 0) begin
                    mv[i] = (mv[i] * (1 << w) + ch) % d;
                end else begin
                    mv[i] = (mv[i] + ch * mw[i]) % d;
                    mw[i] = (mw[i] * (1 << w)) % d;
                end
                mc[i] = mc[i] + w;
                me[i] = 1'b0;
            end
            cs = (mc[i] > 65535) ? 65535 : mc[i];
            ex[i*26 +: 26] = {(!me[i] && mv[i] == 0), me[i], 8'(mv[i]), 16'(cs)};
        end
        rq.push_back(ex);
    endtask

    task automatic rnd_drive();
        rclr = ($urandom_range(0, 15) == 0);
        rvld = ($urandom_range(0, 3) != 0);
        rdin = 8'($urandom);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t e;
        logic [NR*26-1:0] rx;

        tv = '{
            // D=3 W=1 MSB: bits 1,1,0,1
            '{0, 0, 1, 1, 1, 0, 0, 1},
            '{0, 0, 1, 1, 0, 1, 0, 2},
            '{0, 0, 1, 0, 0, 1, 0, 3},
            '{0, 0, 1, 1, 1, 0, 0, 4},
            // D=5 W=4 MSB: 0x7 then 0x3 -> 115
            '{1, 0, 1, 7, 2, 0, 0, 4},
            '{1, 0, 1, 3, 0, 1, 0, 8},
            // D=3 W=1 LSB: values 1,3,3,11
            '{2, 0, 1, 1, 1, 0, 0, 1},
            '{2, 0, 1, 1, 0, 1, 0, 2},
            '{2, 0, 1, 0, 0, 1, 0, 3},
            '{2, 0, 1, 1, 2, 0, 0, 4},
            // D=7: clear+valid, accumulate, hold, clear+valid 0, clear
            '{3, 1, 1, 1, 1, 0, 0, 1},
            '{3, 0, 1, 1, 3, 0, 0, 2},
            '{3, 0, 1, 1, 0, 1, 0, 3},
            '{3, 0, 0, 0, 0, 1, 0, 3},
            '{3, 1, 1, 0, 0, 1, 0, 1},
            '{3, 1, 0, 0, 0, 0, 1, 0},
            // D=3 W=3 CNT_W=4: 6 chunks of 7, count saturates at 15
            '{4, 0, 1, 7, 1, 0, 0, 3},
            '{4, 0, 1, 7, 0, 1, 0, 6},
            '{4, 0, 1, 7, 1, 0, 0, 9},
            '{4, 0, 1, 7, 0, 1, 0, 12},
            '{4, 0, 1, 7, 1, 0, 0, 15},
            '{4, 0, 1, 7, 0, 1, 0, 15}
        };

        idle();
        rclr = 1'b0; rvld = 1'b0; rdin = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++)
            chk_inst($sformatf("reset.k%0d", k), k, 0, 0, 1, 0);
        resetn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            idle();
            clr[tv[i].k] = tv[i].c;
            vld[tv[i].k] = tv[i].v;
            dn[tv[i].k]  = 8'(tv[i].din);
            exq.push_back(tv[i]);
            @(posedge clk);
            #1;
            e = exq.pop_front();
            chk_inst($sformatf("vec%0d", i), e.k, e.rem, int'(e.dout),
                     int'(e.emp), e.cnt);
        end

        // Hold with X on din, then async reset mid-cycle, then restart.
        @(negedge clk); idle(); vld[3] = 1'b1; dn[3] = 8'h01;
        @(negedge clk); dn[3] = 8'h01;
        @(negedge clk); vld[3] = 1'b0; dn[3] = 8'hxx;
        @(posedge clk); #1;
        chk_inst("holdx", 3, 3, 0, 0, 2);
        #2 resetn = 1'b0;
        #1;
        chk_inst("async_rst.k3", 3, 0, 0, 1, 0);
        chk_inst("async_rst.k0", 0, 0, 0, 1, 0);
        @(negedge clk);
        resetn = 1'b1;
        vld[3] = 1'b1; dn[3] = 8'h00;
        @(posedge clk); #1;
        chk_inst("post_rst", 3, 0, 1, 0, 1);
        @(negedge clk); idle();

        // Randomised run across divisors, widths and bit orders.
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        rnd_drive();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (rq.size() == 0) begin
                chk("rnd.queue_empty", 0, 1);
            end else begin
                rx = rq.pop_front();
                for (int i = 0; i < NR; i++)
                    chk($sformatf("rnd.c%0d.D%0d.W%0d.L%0d", cyc, dof(i), wof(i), lof(i)),
                        int'(act_a[i]), int'(rx[i*26 +: 26]));
            end
            rnd_drive();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
